// File: rtl/ldl_arb_rr.sv
// Round-robin arbiter: masked two-pass priority encode, registered one-hot grant held
// until done, abandon or watchdog expiry, with back-to-back re-arbitration on release.
module ldl_arb_rr #(
    parameter int N         = 4,
    parameter int ID_WIDTH  = $clog2(N),
    parameter int MAX_HOLD  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req,
    input  logic                done,
    output logic [N-1:0]        gnt,
    output logic [ID_WIDTH-1:0] gnt_id,
    output logic                gnt_valid,
    output logic                timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_WIDTH'(MAX_HOLD - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(N - 1);

    state_t                state_reg;
    logic [ID_WIDTH-1:0]   ptr_reg;
    logic [CNT_WIDTH-1:0]  hold_cnt_reg;

    logic                  abandon;
    logic                  wd_hit;
    logic                  release_evt;
    logic                  wd_only;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic [ID_WIDTH-1:0]   sel_ptr;
    logic [N-1:0]          sel_req;
    logic [N-1:0]          hi_mask;
    logic [N-1:0]          hi_req;
    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_id;
    logic [N-1:0]          win_onehot;

    // Release causes; the watchdog only counts as the cause when neither other one applies.
    assign abandon     = (state_reg == GRANT) && !req[gnt_id];
    assign wd_hit      = (MAX_HOLD != 0) && (state_reg == GRANT) && (hold_cnt_reg == HOLD_LAST);
    assign release_evt = (state_reg == GRANT) && (done || abandon || wd_hit);
    assign wd_only     = wd_hit && !done && !abandon;

    assign ptr_next = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_WIDTH'(1);

    // On release the search starts just past the outgoing owner, so it can be done in the same edge.
    assign sel_ptr = release_evt ? ptr_next : ptr_reg;
    assign sel_req = (abandon && !done) ? (req & ~gnt) : req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi]    = (gi >= int'(sel_ptr));
            assign win_onehot[gi] = win_found && (win_id == ID_WIDTH'(gi));
        end
    endgenerate

    assign hi_req = sel_req & hi_mask;

    always_comb begin
        win_found = |sel_req;
        win_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel_req[i]) win_id = ID_WIDTH'(i);
        end
        if (|hi_req) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (hi_req[i]) win_id = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            gnt          <= '0;
            gnt_id       <= '0;
            gnt_valid    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    hold_cnt_reg <= '0;
                    if (win_found) begin
                        gnt       <= win_onehot;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_evt) begin
                        ptr_reg      <= ptr_next;
                        hold_cnt_reg <= '0;
                        timeout      <= wd_only;
                        if (win_found) begin
                            gnt       <= win_onehot;
                            gnt_id    <= win_id;
                            gnt_valid <= 1'b1;
                        end else begin
                            gnt       <= '0;
                            gnt_id    <= '0;
                            gnt_valid <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (hold_cnt_reg != '1) begin
                        hold_cnt_reg <= hold_cnt_reg + CNT_WIDTH'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldl_arb_rr.sv
// Self-checking bench for ldl_arb_rr: vector table, watchdog/reset sequences and a
// randomized run against a rotating-search reference model.
module tb_ldl_arb_rr;

    localparam int N         = 4;
    localparam int ID_WIDTH  = 2;
    localparam int MAX_HOLD  = 8;
    localparam int CNT_WIDTH = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req = '0;
    logic                done = 1'b0;
    logic [N-1:0]        gnt;
    logic [ID_WIDTH-1:0] gnt_id;
    logic                gnt_valid;
    logic                timeout;

    int checks = 0;
    int errors = 0;

    ldl_arb_rr #(
        .N(N), .ID_WIDTH(ID_WIDTH), .MAX_HOLD(MAX_HOLD), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                  rst;
        logic [N-1:0]        req;
        logic                done;
        logic [N-1:0]        gnt;
        logic [ID_WIDTH-1:0] id;
        logic                valid;
        logic                to;
    } vec_t;

    vec_t vt[$];

    // reference model state
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    task automatic check(string name, logic [N-1:0] g, logic [ID_WIDTH-1:0] id, logic v, logic to);
        checks++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== {g, id, v, to}) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, expected gnt=%b id=%0d valid=%b timeout=%b",
                     name, gnt, gnt_id, gnt_valid, timeout, g, id, v, to);
        end else begin
            $display("ok   %s: gnt=%b id=%0d valid=%b timeout=%b", name, gnt, gnt_id, gnt_valid, timeout);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(posedge clk); #1;
        check("reset", '0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic step(logic [N-1:0] r, logic d);
        req  = r;
        done = d;
        @(posedge clk); #1;
    endtask

    function automatic void add(bit rs, logic [N-1:0] r, logic d, logic [N-1:0] g, logic [ID_WIDTH-1:0] id, logic v);
        vec_t e;
        e.rst = rs; e.req = r; e.done = d; e.gnt = g; e.id = id; e.valid = v; e.to = 1'b0;
        vt.push_back(e);
    endfunction

    // Rotating search starting at p: first requester found going p, p+1, ... mod N.
    function automatic int rr_pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(logic [N-1:0] r, logic d);
        bit ab, wd;
        logic [N-1:0] rr;
        m_to = 1'b0;
        if (m_owner < 0) begin
            m_owner = rr_pick(r, m_ptr);
            m_hold  = 0;
        end else begin
            ab = !r[m_owner];
            wd = (MAX_HOLD != 0) && (m_hold == MAX_HOLD - 1);
            if (d || ab || wd) begin
                m_to  = wd && !d && !ab;
                m_ptr = (m_owner + 1) % N;
                m_hold = 0;
                rr = r;
                if (ab && !d) rr[m_owner] = 1'b0;
                m_owner = rr_pick(rr, m_ptr);
            end else if (m_hold < (1 << CNT_WIDTH) - 1) begin
                m_hold++;
            end
        end
    endtask

    initial begin
        logic [N-1:0] r;
        logic         d;
        logic [N-1:0] eg;

        // ---------------- vector table ----------------
        add(1, 4'b0110, 0, 4'b0010, 1, 1);   // first grant after reset, ptr=0
        add(0, 4'b0110, 1, 4'b0100, 2, 1);   // done: ptr->2, requester 2 wins
        add(0, 4'b0110, 0, 4'b0100, 2, 1);   // held
        add(1, 4'b0000, 1, 4'b0000, 0, 0);   // done ignored while idle
        add(1, 4'b1111, 0, 4'b0001, 0, 1);
        add(0, 4'b1111, 1, 4'b0010, 1, 1);
        add(0, 4'b1111, 1, 4'b0100, 2, 1);
        add(0, 4'b1111, 1, 4'b1000, 3, 1);
        add(0, 4'b1111, 1, 4'b0001, 0, 1);   // ptr wraps 3 -> 0
        add(0, 4'b1111, 1, 4'b0010, 1, 1);
        add(1, 4'b0001, 0, 4'b0001, 0, 1);
        add(0, 4'b0001, 1, 4'b0001, 0, 1);   // sole requester re-wins, no bubble
        add(0, 4'b0001, 1, 4'b0001, 0, 1);
        add(0, 4'b0001, 1, 4'b0001, 0, 1);
        add(1, 4'b0011, 0, 4'b0001, 0, 1);
        add(0, 4'b0011, 1, 4'b0010, 1, 1);
        add(0, 4'b0001, 0, 4'b0001, 0, 1);   // abandon by 1: wraps to 0, no timeout
        add(0, 4'b0001, 0, 4'b0001, 0, 1);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) apply_reset();
            step(vt[i].req, vt[i].done);
            check($sformatf("vec%0d", i), vt[i].gnt, vt[i].id, vt[i].valid, vt[i].to);
        end

        // ---------------- watchdog ----------------
        apply_reset();
        for (int i = 1; i <= 10; i++) begin
            step(4'b0100, 1'b0);
            check($sformatf("wd_hold%0d", i), 4'b0100, 2, 1'b1, (i == 9));
        end
        for (int i = 11; i <= 16; i++) begin
            step(4'b0100, 1'b0);
            check($sformatf("wd_hold%0d", i), 4'b0100, 2, 1'b1, 1'b0);
        end
        step(4'b0100, 1'b1);                   // done coincides with expiry
        check("wd_done_wins", 4'b0100, 2, 1'b1, 1'b0);
        for (int i = 18; i <= 24; i++) step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);                   // abandon coincides with expiry
        check("wd_abandon_wins", 4'b1000, 3, 1'b1, 1'b0);

        // ---------------- async reset mid-grant ----------------
        apply_reset();
        step(4'b0010, 1'b0);
        check("pre_rst_grant", 4'b0010, 1, 1'b1, 1'b0);
        step(4'b0010, 1'b1);                   // ptr now 2
        check("pre_rst_regrant", 4'b0010, 1, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1 check("async_rst_drop", '0, '0, 1'b0, 1'b0);
        req = 4'b1010;
        done = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ptr0", 4'b0010, 1, 1'b1, 1'b0);

        // ---------------- randomized vs model ----------------
        apply_reset();
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 60) == 0) r = N'($urandom);
            d = ($urandom_range(0, 4) == 0);
            model_step(r, d);
            step(r, d);
            eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            check($sformatf("rand%0d req=%b done=%b", c, r, d), eg,
                  (m_owner >= 0) ? ID_WIDTH'(m_owner) : '0, (m_owner >= 0), m_to);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
